inst_queue: RTL

- Decoupling FIFO between the i-cache output and the decode stage of the out-of-order MIPS core.
- Buffers fetched {pc, instr} pairs and presents the oldest one first-word-fall-through to decode.
- Asserts full so fetch can stall.
- On a branch-mispredict flush it empties itself, then discards stale in-flight i-cache responses until the redirect PC arrives.

---
 rtl/mips_core_pkg.sv | 18 +
 rtl/inst_q_storage.sv | 26 ++
 rtl/inst_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types and widths; holds the instruction-queue entry and state encodings.
package mips_core_pkg;

   localparam int ADDR_WIDTH   = 32;
   localparam int DATA_WIDTH   = 32;
   localparam int INST_Q_DEPTH = 8;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] instr;
   } inst_q_entry_t;

   typedef enum logic {
      IQ_NORMAL,
      IQ_RESYNC
   } inst_q_state_t;

endpackage

// File: rtl/inst_q_storage.sv
// Entry array for the instruction queue: one synchronous write port and one
// asynchronous read port so the head entry falls through to decode.
module inst_q_storage #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with mispredict flush and redirect resync.
//
// state     | meaning
// ----------|-----------------------------------------------------------
// IQ_NORMAL | accept every i-cache beat while not full
// IQ_RESYNC | after a flush; drop beats until in_pc matches the redirect pc
import mips_core_pkg::*;

module inst_queue #(
   parameter int DEPTH      = mips_core_pkg::INST_Q_DEPTH,
   parameter int ADDR_WIDTH = mips_core_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = mips_core_pkg::DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [DATA_WIDTH-1:0]    in_data,
   input  logic [ADDR_WIDTH-1:0]    in_pc,
   input  logic                     flush,
   input  logic [ADDR_WIDTH-1:0]    redirect_pc,
   input  logic                     deq,
   output logic                     out_valid,
   output logic                     out_full,
   output logic [DATA_WIDTH-1:0]    out_data,
   output logic [ADDR_WIDTH-1:0]    out_pc,
   output logic [$clog2(DEPTH):0]   out_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   inst_q_state_t         state_q;
   inst_q_state_t         state_d;
   logic [ADDR_WIDTH-1:0] expected_pc_q;
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         tail_q;
   logic [CW-1:0]         count_q;

   logic                  accept;
   logic                  do_enq;
   logic                  do_deq;
   logic [EW-1:0]         head_entry;

   assign out_valid = (count_q != '0);
   assign out_full  = (count_q == CW'(DEPTH));
   assign out_count = count_q;
   assign out_pc    = head_entry[EW-1:DATA_WIDTH];
   assign out_data  = head_entry[DATA_WIDTH-1:0];

   assign do_deq = deq & out_valid;
   assign do_enq = in_valid & ~out_full & accept;

   always_comb begin
      state_d = state_q;
      accept  = 1'b1;
      case (state_q)
         IQ_NORMAL: begin
            accept = 1'b1;
         end
         IQ_RESYNC: begin
            accept = (in_pc == expected_pc_q);
            if (do_enq) begin
               state_d = IQ_NORMAL;
            end
         end
         default: begin
            state_d = IQ_NORMAL;
         end
      endcase
      if (flush) begin
         state_d = IQ_RESYNC;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IQ_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         expected_pc_q <= '0;
      end else if (flush) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         expected_pc_q <= redirect_pc;
      end else begin
         if (do_enq) begin
            tail_q <= tail_q + PW'(1);
         end
         if (do_deq) begin
            head_q <= head_q + PW'(1);
         end
         case ({do_enq, do_deq})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Writes during flush/reset are harmless but suppressed to keep the array quiet.
   inst_q_storage #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_storage (
      .clk   (clk),
      .we    (do_enq & ~flush & ~rst),
      .waddr (tail_q),
      .wdata ({in_pc, in_data}),
      .raddr (head_q),
      .rdata (head_entry)
   );

endmodule
